// File: rtl/multi_hit_debouncer.sv
`default_nettype none
// ============================================================================
// multi_hit_debouncer
//   Per-channel synchroniser, rising-edge detector and lockout window feeding
//   a lowest-index-first arbiter into a small channel-index event FIFO.
//   Option macro DEBOUNCE_RELEASE_EN: falling edges also restart the lockout.
// Revision: 1.0
// ============================================================================
module multi_hit_debouncer #(
    parameter int CLK_FREQ   = 48000000,
    parameter int LOCKOUT_MS = 10,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         unsync_hit,
    output logic [NUM_CH-1:0]         sync_hit,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    output logic                      evt_overflow,
    input  logic                      clear_overflow
);

    localparam int WAIT_CYCLES = (CLK_FREQ / 1000) * LOCKOUT_MS;
    localparam int CW          = $clog2(WAIT_CYCLES + 1);
    localparam int CHW         = $clog2(NUM_CH);
    localparam int PW          = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_WAIT = CW'(WAIT_CYCLES);

    logic [NUM_CH-1:0] r_s0;
    logic [NUM_CH-1:0] r_s1;
    logic [NUM_CH-1:0] r_sync;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] w_accept;
    logic [NUM_CH-1:0] w_grant;
    logic [CHW-1:0]    w_grant_idx;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf_new;
    logic [PW:0]       r_wr_ptr;
    logic [PW:0]       r_rd_ptr;
    logic [CHW-1:0]    r_mem [FIFO_DEPTH];
    logic              r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0   <= '0;
            r_s1   <= '0;
            r_sync <= '0;
        end else begin
            r_s0   <= unsync_hit;
            r_s1   <= r_s0;
            r_sync <= w_accept;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic          w_rise;
        logic          w_fall;

        assign w_rise       = r_s0[gi] & ~r_s1[gi];
        assign w_fall       = ~r_s0[gi] & r_s1[gi];
        assign w_accept[gi] = w_rise & (r_cnt == '0);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end else if (w_rise) begin
                r_cnt <= C_WAIT;
`ifdef DEBOUNCE_RELEASE_EN
            end else if (w_fall) begin
                r_cnt <= C_WAIT;
`endif
            end
        end

`ifndef DEBOUNCE_RELEASE_EN
        logic w_fall_unused;
        assign w_fall_unused = w_fall;
`endif
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_pop   = ~w_empty & evt_ready;

    // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
    always_comb begin
        w_grant_idx = '0;
        w_grant     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_grant_idx = CHW'(i);
            end
        end
        w_push = (|r_pending) & (~w_full | w_pop);
        if (w_push) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_ovf_new = |(w_accept & r_pending & ~w_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_grant) | w_accept;
            r_overflow <= w_ovf_new | (r_overflow & ~clear_overflow);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= w_grant_idx;
        end
    end

    assign sync_hit     = r_sync;
    assign evt_valid    = ~w_empty;
    assign evt_ch       = w_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];
    assign evt_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_multi_hit_debouncer.sv
`default_nettype none
// ============================================================================
// tb_multi_hit_debouncer
//   Directed and randomized stimulus against a cycle-level behavioural model.
// Revision: 1.0
// ============================================================================
module tb_multi_hit_debouncer;

    localparam int NCH  = 4;
    localparam int DEP  = 4;
    localparam int WAIT = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] unsync_hit = '0;
    logic [3:0] sync_hit;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [1:0] evt_ch;
    logic       evt_overflow;
    logic       clear_overflow = 1'b0;

    int checks = 0;
    int errors = 0;

    multi_hit_debouncer #(
        .CLK_FREQ  (1000),
        .LOCKOUT_MS(5),
        .NUM_CH    (NCH),
        .FIFO_DEPTH(DEP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .unsync_hit    (unsync_hit),
        .sync_hit      (sync_hit),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_ch        (evt_ch),
        .evt_overflow  (evt_overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: inputs seen at the previous two edges, absolute lockout deadlines,
    // pending flags and a queue of channel indices.
    int         cyc = 0;
    bit   [3:0] a1 = '0;
    bit   [3:0] a2 = '0;
    int         lock_until[NCH] = '{-1, -1, -1, -1};
    bit   [3:0] pend = '0;
    int         q[$];
    bit         ovf = 1'b0;
    bit   [3:0] exp_sync = '0;
    bit   [3:0] acc;
    int         g;
    bit         m_pop;
    bit         m_push;
    bit         new_ovf;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            a1 = '0;
            a2 = '0;
            pend = '0;
            q.delete();
            ovf = 1'b0;
            exp_sync = '0;
            for (int i = 0; i < NCH; i++) lock_until[i] = -1;
        end else begin
            acc = '0;
            for (int i = 0; i < NCH; i++) begin
                if (cyc > lock_until[i]) begin
                    if (a1[i] && !a2[i]) begin
                        acc[i] = 1'b1;
                        lock_until[i] = cyc + WAIT;
                    end
`ifdef DEBOUNCE_RELEASE_EN
                    else if (!a1[i] && a2[i]) begin
                        lock_until[i] = cyc + WAIT;
                    end
`endif
                end
            end
            g = -1;
            for (int i = NCH - 1; i >= 0; i--) if (pend[i]) g = i;
            m_pop  = (q.size() > 0) && evt_ready;
            m_push = (g >= 0) && ((q.size() < DEP) || m_pop);
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back(g);
                pend[g] = 1'b0;
            end
            new_ovf = |(acc & pend);
            ovf = new_ovf | (ovf & !clear_overflow);
            pend = pend | acc;
            exp_sync = acc;
            a2 = a1;
            a1 = unsync_hit;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("cyc_sync_hit", int'(sync_hit), int'(exp_sync));
            check("cyc_evt_valid", int'(evt_valid), (q.size() > 0) ? 1 : 0);
            check("cyc_evt_ch", int'(evt_ch), (q.size() > 0) ? q[0] : 0);
            check("cyc_overflow", int'(evt_overflow), int'(ovf));
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_drain();
        unsync_hit = '0;
        evt_ready  = 1'b1;
        wait_n(12);
    endtask

    initial begin
        wait_n(3);
        check("reset_sync_hit", int'(sync_hit), 0);
        check("reset_evt_valid", int'(evt_valid), 0);
        check("reset_evt_ch", int'(evt_ch), 0);
        check("reset_overflow", int'(evt_overflow), 0);
        reset = 1'b0;
        wait_n(2);

        // Single clean press on channel 2.
        evt_ready  = 1'b0;
        unsync_hit = 4'b0100;
        wait_n(1);
        check("press_sync_early", int'(sync_hit), 0);
        wait_n(1);
        check("press_sync_pulse", int'(sync_hit), 4);
        wait_n(1);
        check("press_sync_done", int'(sync_hit), 0);
        check("press_valid", int'(evt_valid), 1);
        check("press_ch", int'(evt_ch), 2);
        evt_ready = 1'b1;
        wait_n(1);
        check("press_popped", int'(evt_valid), 0);
        idle_drain();

        // Bouncy channel 0.
        for (int i = 0; i < 4; i++) begin
            unsync_hit[0] = ~unsync_hit[0];
            wait_n(1);
        end
        unsync_hit = '0;
        wait_n(4);
        unsync_hit = 4'b0001;
        wait_n(3);
        idle_drain();

        // Simultaneous strikes on channels 3, 1, 0.
        unsync_hit = 4'b1011;
        wait_n(1);
        unsync_hit = '0;
        wait_n(2);
        check("simul_ch_first", int'(evt_ch), 0);
        wait_n(1);
        check("simul_ch_second", int'(evt_ch), 1);
        wait_n(1);
        check("simul_ch_third", int'(evt_ch), 3);
        check("simul_no_ovf", int'(evt_overflow), 0);
        idle_drain();

        // Fill the FIFO, leave ch0 pending, then overflow it.
        evt_ready  = 1'b0;
        unsync_hit = 4'b1111;
        wait_n(1);
        unsync_hit = '0;
        wait_n(9);
        unsync_hit = 4'b0001;
        wait_n(1);
        unsync_hit = '0;
        wait_n(8);
        unsync_hit = 4'b0001;
        wait_n(2);
        check("ovf_set", int'(evt_overflow), 1);
        check("ovf_head", int'(evt_ch), 0);
        clear_overflow = 1'b1;
        wait_n(1);
        clear_overflow = 1'b0;
        check("ovf_cleared", int'(evt_overflow), 0);
        unsync_hit = '0;
        evt_ready  = 1'b1;
        wait_n(1);
        evt_ready  = 1'b0;
        wait_n(1);
        check("full_swap_head", int'(evt_ch), 1);
        idle_drain();

        // Reset during lockout with queued events, then an immediate hit.
        evt_ready  = 1'b0;
        unsync_hit = 4'b0110;
        wait_n(4);
        reset = 1'b1;
        wait_n(1);
        reset = 1'b0;
        check("rst_mid_valid", int'(evt_valid), 0);
        check("rst_mid_sync", int'(sync_hit), 0);
        unsync_hit = '0;
        wait_n(1);
        unsync_hit = 4'b0010;
        wait_n(2);
        check("rst_new_hit", int'(sync_hit), 2);
        idle_drain();

        // Long press with bouncy release.
        unsync_hit = 4'b0001;
        wait_n(8);
        for (int i = 0; i < 4; i++) begin
            unsync_hit[0] = ~unsync_hit[0];
            wait_n(1);
        end
        unsync_hit = '0;
        idle_drain();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 2) == 0)
                unsync_hit[$urandom_range(0, 3)] = ~unsync_hit[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0)
                unsync_hit = 4'($urandom);
            evt_ready      = ((n / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                  : ($urandom_range(0, 5) == 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
            reset          = ($urandom_range(0, 399) == 0);
            wait_n(1);
        end
        reset          = 1'b0;
        clear_overflow = 1'b0;
        unsync_hit     = '0;
        wait_n(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_hit_debouncer.md
# multi_hit_debouncer

N-channel hit front end for the pad inputs: each channel is double-flop synchronised, edge-detected and subject to its own lockout window, producing a single-cycle `sync_hit` pulse per accepted hit. Accepted hits are also serialised into a small event FIFO, one channel index per entry, behind a valid/ready handshake. Downstream sound/scoring logic can consume hits one at a time without missing simultaneous strikes.

## Interface
- `CLK_FREQ`, 48000000, clock frequency in Hz
- `LOCKOUT_MS`, 10, per-channel lockout in ms; WAIT_CYCLES = (CLK_FREQ/1000)*LOCKOUT_MS, must be ≥ 1
- `NUM_CH`, 4, number of hit channels, ≥ 2
- `FIFO_DEPTH`, 8, event FIFO entries, power of two, ≥ 2
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `unsync_hit`  in  NUM_CH  raw asynchronous pad inputs, bit i = channel i
- `sync_hit`  out  NUM_CH  one-cycle pulse per accepted hit, per channel
- `evt_valid`  out  1  FIFO non-empty; head entry on `evt_ch`
- `evt_ready`  in  1  consumer accepts head when `evt_valid && evt_ready`
- `evt_ch`  out  $clog2(NUM_CH)  channel index of head event
- `evt_overflow`  out  1  sticky: an accepted hit could not be queued
- `clear_overflow`  in  1  clears `evt_overflow`

## Operation
- Reset: all sync flops, counters, pending bits, FIFO pointers cleared; `sync_hit`=0, `evt_valid`=0, `evt_ch`=0, `evt_overflow`=0.
- Per channel: two-flop synchroniser (s0, s1); rising edge = s0 && !s1.
- Lockout counter per channel, width $clog2(WAIT_CYCLES+1). If counter > 0: decrement, edges ignored and discarded (not deferred). Else on rising edge: `sync_hit[i]` pulses, counter loads WAIT_CYCLES, pending[i] sets.
- Arbiter: each cycle, if any pending bit set and FIFO not full, the lowest-index pending channel is written to the FIFO and its pending bit cleared. One write per cycle.
- FIFO full: pending bits hold; no loss until a channel re-hits.
- Overflow: a hit accepted on channel i while pending[i] is still set → `evt_overflow` sets, the new event is dropped (pending[i] stays 1). `sync_hit[i]` still pulses.
- Same cycle pending[i] is pushed and a new hit on i accepted: pending[i] stays set, no overflow.
- Pop on `evt_valid && evt_ready`; simultaneous push and pop allowed when full (pop frees slot, push lands same edge). `evt_ready` while empty: no effect.
- `clear_overflow` and a new overflow in the same cycle: overflow wins (stays 1).
- Pointers wrap modulo FIFO_DEPTH; full/empty tracked with an extra pointer bit.

## Timing
- Input rises before edge 1: s0=1 after edge 1; `sync_hit` and pending set after edge 2 (2-cycle latency); FIFO write at edge 3; `evt_valid` high after edge 3 (empty FIFO).
- Hit accepted at edge t: edges during t+1 … t+WAIT_CYCLES ignored; edge reaching the detector at t+WAIT_CYCLES+1 accepted.
- `sync_hit` exactly one cycle wide; `evt_valid`/`evt_ch` registered, stable until popped.
- K channels hitting in the same cycle drain into the FIFO in ascending index order, one per cycle.
- Reset mid-operation: all state cleared on that edge; in-flight events lost; outputs at reset values the following cycle.

## Configuration
- `DEBOUNCE_RELEASE_EN`: when defined, a falling edge (!s0 && s1) with counter == 0 also reloads the lockout counter (no pulse, no event), so release bounce cannot retrigger. When undefined, falling edges are ignored entirely and only rising edges affect the counter.

## Test plan
Benches use CLK_FREQ=1000, LOCKOUT_MS=5 (WAIT_CYCLES=5), NUM_CH=4, FIFO_DEPTH=4.
- Single clean press on ch2 → `sync_hit`=4'b0100 for one cycle 2 cycles after input; `evt_valid`=1, `evt_ch`=2 one cycle later; pop empties FIFO.
- Bouncy ch0 (toggle every cycle for 4 cycles) → exactly one `sync_hit[0]` and one event; rising edge 6 cycles after accept → second hit accepted.
- Channels 3,1,0 rise in the same cycle, `evt_ready`=1 → `evt_ch` sequence 0,1,3 on consecutive cycles, no overflow.
- `evt_ready`=0, hits on ch0..3 then ch0 again after lockout → FIFO holds 0,1,2,3, second ch0 pends; third ch0 hit → `evt_overflow`=1; `clear_overflow` → 0.
- Full FIFO with pop and pending push in the same cycle → count stays 4, order preserved.
- Assert `reset` during lockout with queued events → all outputs 0 next cycle; immediate new hit accepted without lockout. With `DEBOUNCE_RELEASE_EN`: press, hold 8 cycles, bouncy release → no second hit.
